// File: rtl/ysyx_22050019_if_pkg.sv
// Shared types and constants for the ysyx_22050019 instruction fetch unit.
package ysyx_22050019_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;
  localparam logic [31:0] INST_BUBBLE      = 32'h0;

  // Memory is addressed in doublewords; the low three PC bits never reach the bus.
  function automatic logic [63:0] dword_addr(input logic [63:0] pc);
    return {pc[63:3], 3'b000};
  endfunction

  // Pick the 32-bit instruction out of the returned doubleword using PC bit 2.
  function automatic logic [31:0] select_word(input logic [63:0] data, input logic upper);
    return upper ? data[63:32] : data[31:0];
  endfunction

endpackage

// File: rtl/ysyx_22050019_if_fetch_if.sv
// Valid/ready instruction memory bus between the fetch unit (master) and memory (slave).
// Fields map to mem_req_valid_o/mem_req_ready_i/mem_req_addr_o and
// mem_rsp_valid_i/mem_rsp_data_i/mem_rsp_ready_o as seen from the fetch unit.
interface ysyx_22050019_if_fetch_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        rsp_ready;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ysyx_22050019_if_perf.sv
// Fetch performance counters; only present when YSYX_22050019_IF_PERF_EN is defined.
// Both counters start at zero and wrap at 64 bits.
`ifdef YSYX_22050019_IF_PERF_EN
module ysyx_22050019_if_perf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_evt_i,
  input  logic        kill_evt_i,
  output logic [63:0] perf_fetch_cnt_o,
  output logic [63:0] perf_kill_cnt_o
);
  logic [63:0] fetch_cnt_d, fetch_cnt_q;
  logic [63:0] kill_cnt_d,  kill_cnt_q;

  // Bump each counter on its one-cycle event strobe.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q + (fetch_evt_i ? 64'd1 : 64'd0);
    kill_cnt_d  = kill_cnt_q  + (kill_evt_i  ? 64'd1 : 64'd0);
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 64'd0;
      kill_cnt_q  <= 64'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      kill_cnt_q  <= kill_cnt_d;
    end
  end

  assign perf_fetch_cnt_o = fetch_cnt_q;
  assign perf_kill_cnt_o  = kill_cnt_q;
endmodule
`endif

// File: rtl/ysyx_22050019_if_fetch.sv
// Instruction fetch unit: one outstanding doubleword read at a time, presents
// pc/inst/commite to IF/ID, holds while stalled and discards work on a jump.
// Optional perf counters are enabled by defining YSYX_22050019_IF_PERF_EN.
module ysyx_22050019_if_fetch
  import ysyx_22050019_if_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                            clk,
  input  logic                            rst_n,
  ysyx_22050019_if_fetch_if.master        mem,
  input  logic                            jump_valid_i,
  input  logic [63:0]                     jump_pc_i,
  input  logic                            if_id_stall_i,
  output logic [63:0]                     pc_o,
  output logic [31:0]                     inst_o,
  output logic                            commite_o
`ifdef YSYX_22050019_IF_PERF_EN
  ,
  output logic [63:0]                     perf_fetch_cnt_o,
  output logic [63:0]                     perf_kill_cnt_o
`endif
);

  fetch_state_e state_d, state_q;
  logic [63:0]  fetch_pc_d, fetch_pc_q;
  logic         kill_d, kill_q;
  logic         req_valid_d, req_valid_q;
  logic [63:0]  req_addr_d, req_addr_q;
  logic         rsp_ready_d, rsp_ready_q;
  logic [63:0]  pc_d, pc_q;
  logic [31:0]  inst_d, inst_q;
  logic         commite_d, commite_q;

  logic [63:0]  jump_target;
  logic [63:0]  seq_pc;

  assign jump_target = {jump_pc_i[63:2], 2'b00};
  assign seq_pc      = fetch_pc_q + 64'd4;

  // Next-state logic: a jump always retargets fetch_pc; an in-flight read is
  // never retracted, it is just marked with kill and thrown away on return.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    kill_d      = kill_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    rsp_ready_d = rsp_ready_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    commite_d   = commite_q;
    case (state_q)
      IDLE: begin
        fetch_pc_d  = jump_valid_i ? jump_target : fetch_pc_q;
        req_valid_d = 1'b1;
        req_addr_d  = dword_addr(fetch_pc_d);
        state_d     = REQ;
      end
      REQ: begin
        if (jump_valid_i) begin
          fetch_pc_d = jump_target;
          kill_d     = 1'b1;
        end
        if (mem.req_ready) begin
          req_valid_d = 1'b0;
          rsp_ready_d = 1'b1;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (mem.rsp_valid) begin
          rsp_ready_d = 1'b0;
          if (kill_q || jump_valid_i) begin
            kill_d      = 1'b0;
            fetch_pc_d  = jump_valid_i ? jump_target : fetch_pc_q;
            req_valid_d = 1'b1;
            req_addr_d  = dword_addr(fetch_pc_d);
            state_d     = REQ;
          end else begin
            commite_d = 1'b1;
            pc_d      = fetch_pc_q;
            inst_d    = select_word(mem.rsp_data, fetch_pc_q[2]);
            state_d   = HOLD;
          end
        end else if (jump_valid_i) begin
          fetch_pc_d = jump_target;
          kill_d     = 1'b1;
        end
      end
      HOLD: begin
        if (jump_valid_i || !if_id_stall_i) begin
          commite_d   = 1'b0;
          inst_d      = INST_BUBBLE;
          fetch_pc_d  = jump_valid_i ? jump_target : seq_pc;
          req_valid_d = 1'b1;
          req_addr_d  = dword_addr(fetch_pc_d);
          state_d     = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset returns to IDLE immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      kill_q      <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= 64'd0;
      rsp_ready_q <= 1'b0;
      pc_q        <= 64'd0;
      inst_q      <= INST_BUBBLE;
      commite_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      kill_q      <= kill_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      rsp_ready_q <= rsp_ready_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      commite_q   <= commite_d;
    end
  end

  assign mem.req_valid = req_valid_q;
  assign mem.req_addr  = req_addr_q;
  assign mem.rsp_ready = rsp_ready_q;
  assign pc_o          = pc_q;
  assign inst_o        = inst_q;
  assign commite_o     = commite_q;

  // Memory must only answer while a read is outstanding.
  rsp_only_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
    mem.rsp_valid |-> (state_q == WAIT));

`ifdef YSYX_22050019_IF_PERF_EN
  logic fetch_evt;
  logic kill_evt;

  assign fetch_evt = (state_q == WAIT) && mem.rsp_valid && !kill_q && !jump_valid_i;
  assign kill_evt  = ((state_q == WAIT) && mem.rsp_valid && (kill_q || jump_valid_i)) ||
                     ((state_q == HOLD) && jump_valid_i);

  ysyx_22050019_if_perf u_perf (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_evt_i      (fetch_evt),
    .kill_evt_i       (kill_evt),
    .perf_fetch_cnt_o (perf_fetch_cnt_o),
    .perf_kill_cnt_o  (perf_kill_cnt_o)
  );
`endif

endmodule

// File: tb/tb_ysyx_22050019_if_fetch.sv
// Testbench for ysyx_22050019_if_fetch: memory model, directed scenarios and a
// randomized phase, with a scoreboard that checks every instruction IF/ID captures.
`timescale 1ns/1ps
module tb_ysyx_22050019_if_fetch;
  import ysyx_22050019_if_pkg::*;

  localparam logic [63:0] BOOT_PC = RESET_PC_DEFAULT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump_valid = 1'b0;
  logic [63:0] jump_pc = 64'd0;
  logic        if_id_stall = 1'b0;
  logic [63:0] pc_o;
  logic [31:0] inst_o;
  logic        commite_o;
`ifdef YSYX_22050019_IF_PERF_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_kill_cnt;
`endif

  ysyx_22050019_if_fetch_if mem_bus();

  ysyx_22050019_if_fetch #(.RESET_PC(BOOT_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem           (mem_bus),
    .jump_valid_i  (jump_valid),
    .jump_pc_i     (jump_pc),
    .if_id_stall_i (if_id_stall),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .commite_o     (commite_o)
`ifdef YSYX_22050019_IF_PERF_EN
    ,
    .perf_fetch_cnt_o (perf_fetch_cnt),
    .perf_kill_cnt_o  (perf_kill_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference program: the word at any PC is a fixed function of that PC.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [31:0] inst_at(input logic [63:0] pc);
    return pc[31:0] ^ 32'h5A5A_0003;
  endfunction

  function automatic logic [63:0] mem_dword(input logic [63:0] addr);
    logic [63:0] a;
    a = {addr[63:3], 3'b000};
    return {inst_at(a + 64'd4), inst_at(a)};
  endfunction

  function automatic void model_push(input logic [63:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = inst_at(pc);
    exp_q.push_back(e);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drive ID-side inputs; a jump restarts the expected instruction stream at the target.
  task automatic applyStimulus(input bit jv, input logic [63:0] jt, input bit st);
    jump_valid  = jv;
    jump_pc     = jt;
    if_id_stall = st;
    if (jv) begin
      exp_q.delete();
      model_push({jt[63:2], 2'b00});
    end
  endtask

  // Memory model state
  bit          mem_rand = 1'b0;
  int          lat_fixed = 0;
  bit          mem_pending = 1'b0;
  int          mem_cnt = 0;
  logic [63:0] pend_addr = 64'd0;
  int          rsp_fires = 0;
  logic [63:0] req_log[$];

  // Monitor statistics
  int captures = 0;
  int commit_rises = 0;
  int held_discards = 0;

  // Memory: accepts one read, answers 1+latency cycles later with the doubleword.
  initial begin : mem_model
    bit req_fire;
    bit rsp_fire;
    logic [63:0] addr_s;
    mem_bus.req_ready = 1'b1;
    mem_bus.rsp_valid = 1'b0;
    mem_bus.rsp_data  = 64'd0;
    forever begin
      @(negedge clk);
      req_fire = rst_n && mem_bus.req_valid && mem_bus.req_ready;
      rsp_fire = rst_n && mem_bus.rsp_valid && mem_bus.rsp_ready;
      addr_s   = mem_bus.req_addr;
      if (req_fire) req_log.push_back(addr_s);
      @(posedge clk);
      #1;
      if (rsp_fire) begin
        mem_bus.rsp_valid = 1'b0;
        rsp_fires++;
      end
      if (req_fire) begin
        mem_pending = 1'b1;
        pend_addr   = addr_s;
        mem_cnt     = mem_rand ? int'($urandom_range(3, 0)) : lat_fixed;
      end
      if (mem_pending) begin
        if (mem_cnt == 0) begin
          mem_bus.rsp_valid = 1'b1;
          mem_bus.rsp_data  = mem_dword(pend_addr);
          mem_pending       = 1'b0;
        end else begin
          mem_cnt--;
        end
      end
      mem_bus.req_ready = mem_rand ? ($urandom_range(3, 0) != 0) : 1'b1;
    end
  end

  // Scoreboard monitor: compares every IF/ID capture against the expected stream.
  initial begin : monitor
    exp_t e;
    logic prev_commite;
    prev_commite = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (commite_o && !prev_commite) commit_rises++;
        if (commite_o && jump_valid) held_discards++;
        if (commite_o && !if_id_stall && !jump_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_capture: got pc %h expected no instruction", pc_o);
          end else begin
            e = exp_q.pop_front();
            checkOutput("capture_pc", pc_o, e.pc);
            checkOutput("capture_inst", {32'd0, inst_o}, {32'd0, e.inst});
            captures++;
            model_push(e.pc + 64'd4);
          end
        end
        if (!commite_o) checkOutput("bubble_inst", {32'd0, inst_o}, 64'd0);
        checkOutput("single_outstanding",
                    {63'd0, mem_bus.req_valid && (mem_pending || mem_bus.rsp_valid)}, 64'd0);
        if (mem_bus.req_valid) checkOutput("req_aligned", {61'd0, mem_bus.req_addr[2:0]}, 64'd0);
      end
      prev_commite = commite_o;
    end
  end

  task automatic waitCaptures(input int more, input string name);
    int target;
    int i;
    target = captures + more;
    i = 0;
    while (captures < target && i < 60) begin
      @(posedge clk);
      #1;
      i++;
    end
    checkOutput(name, {63'd0, captures >= target}, 64'd1);
  endtask

  task automatic waitRspReady(input string name);
    int i;
    i = 0;
    while (!mem_bus.rsp_ready && i < 30) begin
      @(posedge clk);
      #1;
      i++;
    end
    checkOutput(name, {63'd0, mem_bus.rsp_ready}, 64'd1);
  endtask

  task automatic waitNewRequest(input int n, input string name, output bit saw_commit);
    int i;
    i = 0;
    saw_commit = 1'b0;
    while (req_log.size() <= n && i < 40) begin
      @(posedge clk);
      #1;
      if (commite_o) saw_commit = 1'b1;
      i++;
    end
    checkOutput(name, {63'd0, req_log.size() > n}, 64'd1);
  endtask

  initial begin : stimulus
    logic [63:0] snap_pc;
    logic [31:0] snap_inst;
    int n;
    int i;
    bit saw;
    bit jv;
    bit st;
    logic [63:0] jt;

    applyStimulus(1'b0, 64'd0, 1'b1);
    model_push(BOOT_PC);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_valid", {63'd0, mem_bus.req_valid}, 64'd0);
    checkOutput("rst_req_addr", mem_bus.req_addr, 64'd0);
    checkOutput("rst_rsp_ready", {63'd0, mem_bus.rsp_ready}, 64'd0);
    checkOutput("rst_pc", pc_o, 64'd0);
    checkOutput("rst_inst", {32'd0, inst_o}, 64'd0);
    checkOutput("rst_commite", {63'd0, commite_o}, 64'd0);
    rst_n = 1'b1;

    // Zero-wait memory: REQ after edge 1, WAIT after edge 2, instruction presented after edge 3.
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        checkOutput("first_req_valid", {63'd0, mem_bus.req_valid}, 64'd1);
        checkOutput("first_req_addr", mem_bus.req_addr, BOOT_PC);
      end
      checkOutput("first_commit_timing", {63'd0, commite_o}, {63'd0, k == 3});
    end

    // Stalled HOLD: output frozen and no new request for 5 cycles.
    snap_pc   = pc_o;
    snap_inst = inst_o;
    checkOutput("hold_pc_first", snap_pc, BOOT_PC);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checkOutput("stall_pc", pc_o, snap_pc);
      checkOutput("stall_inst", {32'd0, inst_o}, {32'd0, snap_inst});
      checkOutput("stall_commite", {63'd0, commite_o}, 64'd1);
      checkOutput("stall_no_req", {63'd0, mem_bus.req_valid}, 64'd0);
    end
    applyStimulus(1'b0, 64'd0, 1'b0);
    waitCaptures(3 - captures, "three_captures");
    checkOutput("req_count", req_log.size(), 64'd3);
    checkOutput("req0", req_log[0], 64'h8000_0000);
    checkOutput("req1", req_log[1], 64'h8000_0000);
    checkOutput("req2", req_log[2], 64'h8000_0008);

    // Jump while waiting; the response arrives three cycles later and must be dropped.
    lat_fixed = 3;
    waitRspReady("wait_state_a");
    n = req_log.size();
    applyStimulus(1'b1, 64'h8000_0100, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 64'd0, 1'b0);
    waitNewRequest(n, "wait_jump_new_req", saw);
    checkOutput("wait_jump_no_commit", {63'd0, saw}, 64'd0);
    checkOutput("wait_jump_addr", req_log[n], 64'h8000_0100);
    waitCaptures(1, "after_wait_jump");

    // Jump in the same cycle as the response.
    lat_fixed = 1;
    waitRspReady("wait_state_b");
    @(posedge clk);
    #1;
    n = req_log.size();
    applyStimulus(1'b1, 64'h8000_0400, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 64'd0, 1'b0);
    waitNewRequest(n, "same_cycle_new_req", saw);
    checkOutput("same_cycle_no_commit", {63'd0, saw}, 64'd0);
    checkOutput("same_cycle_addr", req_log[n], 64'h8000_0400);
    waitCaptures(1, "after_same_cycle");

    // Jump while holding an instruction, with an unaligned target.
    lat_fixed = 0;
    applyStimulus(1'b0, 64'd0, 1'b1);
    i = 0;
    while (!commite_o && i < 30) begin
      @(posedge clk);
      #1;
      i++;
    end
    checkOutput("hold_reached", {63'd0, commite_o}, 64'd1);
    n = req_log.size();
    applyStimulus(1'b1, 64'h8000_0203, 1'b1);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 64'd0, 1'b1);
    checkOutput("hold_jump_commite", {63'd0, commite_o}, 64'd0);
    checkOutput("hold_jump_inst", {32'd0, inst_o}, 64'd0);
    waitNewRequest(n, "hold_jump_new_req", saw);
    checkOutput("hold_jump_addr", req_log[n], 64'h8000_0200);
    i = 0;
    while (!commite_o && i < 30) begin
      @(posedge clk);
      #1;
      i++;
    end
    checkOutput("hold_jump_pc", pc_o, 64'h8000_0200);
    applyStimulus(1'b0, 64'd0, 1'b0);
    waitCaptures(1, "after_hold_jump");

    // 64-bit wrap of the sequential PC.
    applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 64'd0, 1'b0);
    waitCaptures(2, "wrap_captures");

    // Randomized traffic: random ready, latency, stalls and jumps.
    mem_rand = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      @(posedge clk);
      #1;
      jv = ($urandom_range(99, 0) < 6);
      st = ($urandom_range(99, 0) < 30);
      if ($urandom_range(15, 0) == 0)
        jt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0));
      else
        jt = {32'd0, 32'h8000_0000 | ($urandom() & 32'h0000_FFFF)};
      applyStimulus(jv, jt, st);
    end
    applyStimulus(1'b0, 64'd0, 1'b0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("progress", {63'd0, captures >= 150}, 64'd1);
`ifdef YSYX_22050019_IF_PERF_EN
    checkOutput("perf_fetch", perf_fetch_cnt, 64'(commit_rises));
    checkOutput("perf_kill", perf_kill_cnt, 64'((rsp_fires - commit_rises) + held_discards));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
